// File: rtl/slow_ser_pkg.sv
// Shared types and sizing helpers for the slow-clock serializer family.
//
// Contents:
//   ser_state_t : serializer FSM state encoding (IDLE, ARMED, SHIFT, PARITY)
//   cnt_w()     : width of a down-counter that must hold DATA_W-1
package slow_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    SHIFT  = 2'd2,
    PARITY = 2'd3
  } ser_state_t;

  // Bits needed to count DATA_W-1 down to 0; never less than one bit.
  function automatic int cnt_w(input int data_w);
    return (data_w > 2) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/slow_clk_edge_tick.sv
// Edge detector for a divided clock that is itself a register in the
// clk_in domain. Produces one-cycle strobes on each slow_clk edge.
//
// Ports:
//   clk_in    : system clock
//   reset     : synchronous, active-high
//   slow_clk  : divided clock (already synchronous to clk_in)
//   rise_tick : high for one clk_in cycle after slow_clk goes high
//   fall_tick : high for one clk_in cycle after slow_clk goes low
module slow_clk_edge_tick (
  input  logic clk_in,
  input  logic reset,
  input  logic slow_clk,
  output logic rise_tick,
  output logic fall_tick
);

  logic slow_clk_q;

  // Reset value 0 keeps a low slow_clk from producing a fall strobe
  // straight out of reset.
  always_ff @(posedge clk_in) begin
    if (reset) slow_clk_q <= 1'b0;
    else       slow_clk_q <= slow_clk;
  end

  assign fall_tick = slow_clk_q & ~slow_clk;
  assign rise_tick = ~slow_clk_q & slow_clk;

endmodule

// File: rtl/slow_clk_serializer.sv
// Parallel-to-serial converter paced by a divided slow clock. Words are
// accepted over valid/ready in the clk_in domain and shifted out one bit
// per slow_clk period, changing on slow_clk falling edges so a receiver
// can sample on rising edges. Back-to-back words stream with no gap.
//
// Optional build macro SLOW_SER_PARITY_EN appends an even-parity bit
// period after the last data bit of every word.
//
// Ports:
//   clk_in    : system clock
//   reset     : synchronous, active-high
//   slow_clk  : divided clock, register output in clk_in domain
//   s_data    : parallel word to send
//   s_valid   : s_data is valid
//   s_ready   : word is taken this cycle when s_valid is also high
//   ser_data  : registered serial bit stream
//   ser_frame : registered, high during the first bit period of a word
//   busy      : registered, high while a word is armed or shifting
module slow_clk_serializer
  import slow_ser_pkg::*;
#(
  parameter int   DATA_W     = 16,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              slow_clk,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ser_data,
  output logic              ser_frame,
  output logic              busy
);

  localparam int              CNT_W    = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  // The bit on the line is always kept at the outgoing end of sh_q.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d, shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_frame_q, ser_frame_d;
  logic              busy_q, busy_d;
`ifdef SLOW_SER_PARITY_EN
  logic              parity_q, parity_d;
`endif
  logic              fall_tick, unused_rise_tick;
  logic              last_tick, xfer;

  slow_clk_edge_tick u_edge (
    .clk_in    (clk_in),
    .reset     (reset),
    .slow_clk  (slow_clk),
    .rise_tick (unused_rise_tick),
    .fall_tick (fall_tick)
  );

  // last_tick marks the falling edge that ends the current word; a new word
  // taken on that edge is reloaded directly, which gives gapless streaming.
`ifdef SLOW_SER_PARITY_EN
  assign last_tick = (state_q == PARITY) & fall_tick;
`else
  assign last_tick = (state_q == SHIFT) & (cnt_q == '0) & fall_tick;
`endif
  assign s_ready = (state_q == IDLE) | last_tick;
  assign xfer    = s_valid & s_ready;
  assign shifted = shift_word(sh_q);

  // State register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      ser_data_q  <= IDLE_LEVEL;
      ser_frame_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SLOW_SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      ser_data_q  <= ser_data_d;
      ser_frame_q <= ser_frame_d;
      busy_q      <= busy_d;
`ifdef SLOW_SER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (xfer) state_d = ARMED;
      ARMED: if (fall_tick) state_d = SHIFT;
      SHIFT: begin
        if (fall_tick && cnt_q == '0) begin
`ifdef SLOW_SER_PARITY_EN
          state_d = PARITY;
`else
          state_d = xfer ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SLOW_SER_PARITY_EN
      PARITY: if (fall_tick) state_d = xfer ? SHIFT : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    ser_data_d  = ser_data_q;
    ser_frame_d = ser_frame_q;
    busy_d      = busy_q;
`ifdef SLOW_SER_PARITY_EN
    parity_d    = parity_q;
`endif
    if (xfer) begin
      sh_d = s_data;
`ifdef SLOW_SER_PARITY_EN
      parity_d = ^s_data;
`endif
    end
    case (state_q)
      IDLE: if (xfer) busy_d = 1'b1;
      ARMED: begin
        if (fall_tick) begin
          ser_data_d  = first_bit(sh_q);
          ser_frame_d = 1'b1;
          cnt_d       = LAST_CNT;
        end
      end
      SHIFT: begin
        if (fall_tick) begin
          if (cnt_q != '0) begin
            sh_d        = shifted;
            ser_data_d  = first_bit(shifted);
            ser_frame_d = 1'b0;
            cnt_d       = cnt_q - 1'b1;
          end
`ifdef SLOW_SER_PARITY_EN
          else begin
            ser_data_d  = parity_q;
            ser_frame_d = 1'b0;
          end
`else
          else if (xfer) begin
            ser_data_d  = first_bit(s_data);
            ser_frame_d = 1'b1;
            cnt_d       = LAST_CNT;
          end else begin
            ser_data_d  = IDLE_LEVEL;
            ser_frame_d = 1'b0;
            busy_d      = 1'b0;
          end
`endif
        end
      end
`ifdef SLOW_SER_PARITY_EN
      PARITY: begin
        if (fall_tick) begin
          if (xfer) begin
            ser_data_d  = first_bit(s_data);
            ser_frame_d = 1'b1;
            cnt_d       = LAST_CNT;
          end else begin
            ser_data_d  = IDLE_LEVEL;
            ser_frame_d = 1'b0;
            busy_d      = 1'b0;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  assign ser_data  = ser_data_q;
  assign ser_frame = ser_frame_q;
  assign busy      = busy_q;

endmodule
